alu_md_control: RTL and testbench
=================================

ALU_MD_CONTROL -- requirements
Module: alu_md_control

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width.
REQ-002 SHALL have ports (name  dir  width  meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- ALUop  in  2  main-decoder class: 00 ld/st/jalr/auipc, 01 branch, 10 R-type, 11 I-type
- funct3  in  3  instr[14:12]
- funct7_5  in  1  instr[30]
- funct7_0  in  1  instr[25] (M-extension select)
- valid  in  1  instruction in EX is real
- kill  in  1  flush; abandon any M op
- op_a, op_b  in  XLEN  rs1 / rs2 values
- ALUSel  out  4  base ALU operation
- md_op  out  1  current instruction is an M op
- stall  out  1  hold pipeline stages up to and including EX
- md_done  out  1  md_result valid this cycle
- md_result  out  XLEN  M-op result

Function
REQ-003 ALUSel SHALL be combinational with these codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SLT 0100, SLTU 0101, SUB 0110, SRL 0111, SRA 1000, SLL 1001.
REQ-004 ALUop 00 SHALL give ADD, and ALUop 01 SHALL give SUB.
REQ-005 ALUop 10/11 SHALL map funct3 as follows: 000 ADD (SUB if ALUop=10 and funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA by funct7_5, 110 OR, 111 AND.
REQ-006 md_op SHALL be 1 iff ALUop=10 and funct7_0=1, in which case ALUSel SHALL be ADD.
REQ-007 M funct3 SHALL decode as: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 The FSM SHALL have states IDLE, BUSY, DONE.
REQ-009 In IDLE, valid & md_op & !kill SHALL latch op_a, op_b, funct3 and sign info, load count=XLEN, and move to BUSY ("accept").
REQ-010 BUSY SHALL perform one iteration per cycle: radix-2 shift-add multiply on magnitudes, or restoring divide on magnitudes; count decrements; at count=1 the next state is DONE.
REQ-011 Signed ops SHALL use operand magnitudes and negate the result at the end; MULHSU SHALL treat op_a as signed and op_b as unsigned; the multiply product SHALL be 2*XLEN bits wide.
REQ-012 Divide by zero SHALL give quotient all-ones and remainder = op_a, with BUSY lasting exactly 1 cycle.
REQ-013 DIV/REM with op_a = most-negative and op_b = -1 SHALL give quotient = op_a and remainder = 0, with BUSY lasting 1 cycle.
REQ-014 In DONE, md_done SHALL be 1 for exactly one cycle, md_result SHALL hold the result (MUL low half, MULH* high half, DIV* quotient, REM* remainder), and the next state SHALL be IDLE.
REQ-015 md_result SHALL hold its last value until the next DONE.
REQ-016 Latency: md_done SHALL assert XLEN+1 cycles after the accept edge for the normal case, and 2 cycles after for the REQ-012/013 cases.
REQ-017 stall SHALL equal (IDLE & valid & md_op & !kill) | BUSY, and SHALL be 0 in DONE so the pipeline advances with md_result.
REQ-018 While BUSY, changes on op_a, op_b, funct3 and valid SHALL be ignored.
REQ-019 kill in BUSY or DONE SHALL force IDLE next cycle with md_done=0 and md_result unchanged; kill on the final BUSY cycle SHALL win over completion.
REQ-020 Non-M instructions SHALL never change FSM state, and stall SHALL be 0 for them.

Reset
REQ-021 With rst=1 at a clock edge, state SHALL become IDLE, count 0, md_done 0, md_result 0, and internal operand registers 0.
REQ-022 Reset mid-BUSY SHALL abandon the op with no md_done afterwards.
REQ-023 ALUSel and md_op SHALL remain combinational and be unaffected by reset.

Verification (XLEN=32)
REQ-024 ALUop=10, funct3=101, funct7_5=1, funct7_0=0 -> ALUSel=1000, stall=0; ALUop=11, funct3=000, funct7_5=1 -> ALUSel=0010.
REQ-025 MUL 7 * 0xFFFFFFFD -> md_result=0xFFFFFFEB, md_done 33 cycles after accept, stall high for 33 cycles then low.
REQ-026 MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF * 2 -> 0xFFFFFFFF.
REQ-027 DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5, each with md_done 2 cycles after accept; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM of the same -> 0.
REQ-028 DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF; REMU 100 / 7 -> 2.
REQ-029 Accept DIV, then assert kill at cycle 10, and separately rst at cycle 10 -> IDLE next cycle, no md_done, stall=0, md_result=prior value (kill) or 0 (rst).

Source files
------------

// File: rtl/alu_md_control.sv
// ALU control decode plus an iterative multiply/divide unit that shares the EX stage.
// Multiply is radix-2 shift-add and divide is restoring, both on operand magnitudes.
module alu_md_control #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ALUop,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic            valid,
    input  logic            kill,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [3:0]      ALUSel,
    output logic            md_op,
    output logic            stall,
    output logic            md_done,
    output logic [XLEN-1:0] md_result
);
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam int unsigned PW = 2 * XLEN;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_SLT  = 4'b0100;
    localparam logic [3:0] SEL_SLTU = 4'b0101;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SRL  = 4'b0111;
    localparam logic [3:0] SEL_SRA  = 4'b1000;
    localparam logic [3:0] SEL_SLL  = 4'b1001;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      fn_q;
    logic            neg_q;
    logic            spec_q;
    logic [XLEN-1:0] m_q;
    logic [PW-1:0]   acc_q;
    logic            md_done_q;
    logic [XLEN-1:0] md_result_q;

    logic            accept;
    logic            sgn_a, sgn_b, neg_a, neg_b, neg_res, div_zero, div_ovf;
    logic [XLEN-1:0] mag_a, mag_b, spec_res;
    logic [XLEN:0]   mul_sum, div_rs, div_diff;
    logic [PW-1:0]   acc_d, prod_s;
    logic [XLEN-1:0] div_sel, res_d;

    assign md_op = (ALUop == 2'b10) && funct7_0;

    // Base ALU operation select; M instructions keep the adder selected.
    always_comb begin
        ALUSel = SEL_ADD;
        case (ALUop)
            2'b00: ALUSel = SEL_ADD;
            2'b01: ALUSel = SEL_SUB;
            default: begin
                if (!md_op) begin
                    case (funct3)
                        3'b000:  ALUSel = ((ALUop == 2'b10) && funct7_5) ? SEL_SUB : SEL_ADD;
                        3'b001:  ALUSel = SEL_SLL;
                        3'b010:  ALUSel = SEL_SLT;
                        3'b011:  ALUSel = SEL_SLTU;
                        3'b100:  ALUSel = SEL_XOR;
                        3'b101:  ALUSel = funct7_5 ? SEL_SRA : SEL_SRL;
                        3'b110:  ALUSel = SEL_OR;
                        default: ALUSel = SEL_AND;
                    endcase
                end
            end
        endcase
    end

    // Operand conditioning at accept: signedness, magnitudes, result sign, corner cases.
    always_comb begin
        sgn_a    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b110);
        sgn_b    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        neg_a    = sgn_a && op_a[XLEN-1];
        neg_b    = sgn_b && op_b[XLEN-1];
        mag_a    = neg_a ? (XLEN'(0) - op_a) : op_a;
        mag_b    = neg_b ? (XLEN'(0) - op_b) : op_b;
        neg_res  = (funct3[2] && funct3[1]) ? neg_a : (neg_a ^ neg_b);
        div_zero = funct3[2] && (op_b == '0);
        div_ovf  = funct3[2] && !funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
        if (div_zero) spec_res = funct3[1] ? op_a : '1;
        else          spec_res = funct3[1] ? '0 : op_a;
    end

    assign accept = (state_q == IDLE) && valid && md_op && !kill;

    // One multiply or divide iteration, and the signed result it would complete to.
    always_comb begin
        mul_sum  = {1'b0, acc_q[PW-1:XLEN]} + (acc_q[0] ? {1'b0, m_q} : '0);
        div_rs   = acc_q[PW-1:XLEN-1];
        div_diff = div_rs - {1'b0, m_q};
        if (fn_q[2])
            acc_d = {(div_diff[XLEN] ? div_rs[XLEN-1:0] : div_diff[XLEN-1:0]),
                     acc_q[XLEN-2:0], !div_diff[XLEN]};
        else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
        prod_s  = neg_q ? (PW'(0) - acc_d) : acc_d;
        div_sel = fn_q[1] ? acc_d[PW-1:XLEN] : acc_d[XLEN-1:0];
        if (spec_q)                  res_d = acc_q[XLEN-1:0];
        else if (fn_q[2])            res_d = neg_q ? (XLEN'(0) - div_sel) : div_sel;
        else if (fn_q[1:0] == 2'b00) res_d = prod_s[XLEN-1:0];
        else                         res_d = prod_s[PW-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            fn_q        <= '0;
            neg_q       <= 1'b0;
            spec_q      <= 1'b0;
            m_q         <= '0;
            acc_q       <= '0;
            md_done_q   <= 1'b0;
            md_result_q <= '0;
        end else begin
            md_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= BUSY;
                        fn_q    <= funct3;
                        neg_q   <= neg_res;
                        // Corner-case divides resolve in a single BUSY cycle.
                        if (div_zero || div_ovf) begin
                            spec_q <= 1'b1;
                            cnt_q  <= CW'(1);
                            m_q    <= '0;
                            acc_q  <= {XLEN'(0), spec_res};
                        end else begin
                            spec_q <= 1'b0;
                            cnt_q  <= CW'(XLEN);
                            m_q    <= funct3[2] ? mag_b : mag_a;
                            acc_q  <= {XLEN'(0), (funct3[2] ? mag_a : mag_b)};
                        end
                    end
                end
                BUSY: begin
                    if (kill) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                        if (!spec_q) acc_q <= acc_d;
                        if (cnt_q == CW'(1)) begin
                            state_q     <= DONE;
                            md_done_q   <= 1'b1;
                            md_result_q <= res_d;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stall     = accept || (state_q == BUSY);
    assign md_done   = md_done_q;
    assign md_result = md_result_q;

endmodule

// File: tb/tb_alu_md_control.sv
// Randomized self-checking bench for alu_md_control against an arithmetic reference model.
module tb_alu_md_control;
    localparam int unsigned XLEN = 32;

    localparam logic [3:0] S_AND  = 4'b0000;
    localparam logic [3:0] S_OR   = 4'b0001;
    localparam logic [3:0] S_ADD  = 4'b0010;
    localparam logic [3:0] S_XOR  = 4'b0011;
    localparam logic [3:0] S_SLT  = 4'b0100;
    localparam logic [3:0] S_SLTU = 4'b0101;
    localparam logic [3:0] S_SUB  = 4'b0110;
    localparam logic [3:0] S_SRL  = 4'b0111;
    localparam logic [3:0] S_SRA  = 4'b1000;
    localparam logic [3:0] S_SLL  = 4'b1001;

    localparam logic [31:0] MIN32  = 32'h8000_0000;
    localparam logic [31:0] ONES32 = 32'hFFFF_FFFF;

    logic            clk;
    logic            rst;
    logic [1:0]      ALUop;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic            funct7_0;
    logic            valid;
    logic            kill;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      ALUSel;
    logic            md_op;
    logic            stall;
    logic            md_done;
    logic [XLEN-1:0] md_result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_res = 32'd0;

    alu_md_control #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .ALUop     (ALUop),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .funct7_0  (funct7_0),
        .valid     (valid),
        .kill      (kill),
        .op_a      (op_a),
        .op_b      (op_b),
        .ALUSel    (ALUSel),
        .md_op     (md_op),
        .stall     (stall),
        .md_done   (md_done),
        .md_result (md_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_sel(input logic [1:0] op, input logic [2:0] f3,
                                           input logic f75, input logic f70);
        if (op == 2'b00) return S_ADD;
        if (op == 2'b01) return S_SUB;
        if (op == 2'b10 && f70) return S_ADD;
        case (f3)
            3'd0:    return (op == 2'b10 && f75) ? S_SUB : S_ADD;
            3'd1:    return S_SLL;
            3'd2:    return S_SLT;
            3'd3:    return S_SLTU;
            3'd4:    return S_XOR;
            3'd5:    return f75 ? S_SRA : S_SRL;
            3'd6:    return S_OR;
            default: return S_AND;
        endcase
    endfunction

    // Reference M-extension result using native 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] fn, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (fn)
            3'd0: begin up = ua * ub; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); return sp[63:32]; end
            3'd3: begin up = ua * ub; return up[63:32]; end
            3'd4: begin
                if (b == 32'd0) return ONES32;
                if (a == MIN32 && b == ONES32) return a;
                sp = sa / sb; return sp[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return ONES32;
                up = ua / ub; return up[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MIN32 && b == ONES32) return 32'd0;
                sp = sa % sb; return sp[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                up = ua % ub; return up[31:0];
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        if (fn[2] && (b == 32'd0 || (!fn[0] && a == MIN32 && b == ONES32))) return 2;
        return XLEN + 1;
    endfunction

    // Issue one M op at a negedge and follow it to completion; garbage inputs while busy.
    task automatic run_md(input string tag, input logic [2:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        int n_stall;
        bit seen;
        ALUop = 2'b10; funct3 = fn; funct7_5 = 1'b0; funct7_0 = 1'b1;
        valid = 1'b1; kill = 1'b0; op_a = a; op_b = b;
        #1;
        check({tag, "_sel"}, 64'(ALUSel), 64'(S_ADD));
        n_stall = stall ? 1 : 0;
        @(posedge clk);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (md_done) begin
                seen = 1'b1;
            end else begin
                if (stall) n_stall++;
                ALUop = 2'($urandom); funct3 = 3'($urandom); funct7_0 = 1'($urandom);
                funct7_5 = 1'($urandom); valid = 1'($urandom);
                op_a = $urandom; op_b = $urandom;
            end
        end
        check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, "_res"}, 64'(md_result), 64'(exp));
        check({tag, "_stall_cnt"}, 64'(n_stall), 64'(exp_lat));
        check({tag, "_stall_done"}, 64'(stall), 64'd0);
        valid = 1'b0;
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(md_done), 64'd0);
        check({tag, "_hold"}, 64'(md_result), 64'(exp));
        last_res = exp;
    endtask

    task automatic run_rand_md(input string tag);
        logic [2:0]  fn;
        logic [31:0] a, b;
        int unsigned pick;
        fn   = 3'($urandom_range(0, 7));
        a    = $urandom;
        b    = $urandom;
        pick = $urandom_range(0, 5);
        if (pick == 0) b = 32'd0;
        else if (pick == 1) begin a = MIN32; b = ONES32; end
        else if (pick == 2) b = 32'($urandom_range(1, 16));
        run_md(tag, fn, a, b, ref_md(fn, a, b), ref_lat(fn, a, b));
    endtask

    // Start a normal DIV, then kill or reset it during cycle at_cyc after accept.
    task automatic run_abort(input string tag, input bit use_rst, input int at_cyc);
        bit seen;
        ALUop = 2'b10; funct3 = 3'b100; funct7_5 = 1'b0; funct7_0 = 1'b1;
        valid = 1'b1; kill = 1'b0; op_a = 32'd1000; op_b = 32'd7;
        @(posedge clk);
        seen = 1'b0;
        for (int c = 1; c < at_cyc; c++) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
        end
        @(negedge clk);
        if (md_done) seen = 1'b1;
        valid = 1'b0;
        if (use_rst) rst = 1'b1;
        else         kill = 1'b1;
        @(negedge clk);
        rst  = 1'b0;
        kill = 1'b0;
        #1;
        if (use_rst) last_res = 32'd0;
        check({tag, "_stall"}, 64'(stall), 64'd0);
        check({tag, "_done"}, 64'(md_done), 64'd0);
        check({tag, "_res"}, 64'(md_result), 64'(last_res));
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (md_done) seen = 1'b1;
        end
        check({tag, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ALUop = 2'b00; funct3 = 3'd0; funct7_5 = 1'b0; funct7_0 = 1'b0;
        valid = 1'b0; kill = 1'b0; op_a = '0; op_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_done", 64'(md_done), 64'd0);
        check("rst_res", 64'(md_result), 64'd0);
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_sel", 64'(ALUSel), 64'(S_ADD));
        rst = 1'b0;
        @(negedge clk);

        ALUop = 2'b10; funct3 = 3'b101; funct7_5 = 1'b1; funct7_0 = 1'b0; valid = 1'b1;
        #1;
        check("sra_sel", 64'(ALUSel), 64'(S_SRA));
        check("sra_stall", 64'(stall), 64'd0);
        ALUop = 2'b11; funct3 = 3'b000; funct7_5 = 1'b1;
        #1;
        check("addi_sel", 64'(ALUSel), 64'(S_ADD));
        @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            ALUop = 2'($urandom); funct3 = 3'($urandom); funct7_5 = 1'($urandom);
            funct7_0 = 1'($urandom); valid = 1'($urandom);
            if (ALUop == 2'b10) funct7_0 = 1'b0;
            op_a = $urandom; op_b = $urandom;
            #1;
            check("dec_sel", 64'(ALUSel), 64'(ref_sel(ALUop, funct3, funct7_5, funct7_0)));
            check("dec_mdop", 64'(md_op), 64'd0);
            check("dec_stall", 64'(stall), 64'd0);
            @(negedge clk);
            check("dec_nodone", 64'(md_done), 64'd0);
        end
        valid = 1'b0;

        run_md("mul",    3'd0, 32'd7,      32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_md("mulh",   3'd1, MIN32,      MIN32,         32'h4000_0000, 33);
        run_md("mulhu",  3'd3, ONES32,     ONES32,        32'hFFFF_FFFE, 33);
        run_md("mulhsu", 3'd2, ONES32,     32'd2,         32'hFFFF_FFFF, 33);
        run_md("divu0",  3'd5, 32'd5,      32'd0,         32'hFFFF_FFFF, 2);
        run_md("rem0",   3'd6, 32'd5,      32'd0,         32'd5,         2);
        run_md("divovf", 3'd4, MIN32,      ONES32,        MIN32,         2);
        run_md("removf", 3'd6, MIN32,      ONES32,        32'd0,         2);
        run_md("divneg", 3'd4, 32'hFFFF_FFF9, 32'd2,      32'hFFFF_FFFD, 33);
        run_md("remneg", 3'd6, 32'hFFFF_FFF9, 32'd2,      32'hFFFF_FFFF, 33);
        run_md("remu",   3'd7, 32'd100,    32'd7,         32'd2,         33);

        for (int i = 0; i < 24; i++) run_rand_md("rnd");

        run_abort("kill10", 1'b0, 10);
        run_abort("kill_last", 1'b0, 32);
        run_abort("rst10", 1'b1, 10);
        run_rand_md("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
